key_mode_multi: RTL and testbench
=================================

// Module: key_mode_multi
// PURPOSE
//   Multi-channel push-button front end. Per key: 2-FF synchroniser, debounce,
//   press/release pulses and a wrap-around mode counter with MODE_NUM states.
//   Generalises single-key, 2-state mode toggling to N keys and N-state modes,
//   with optional long-press detection. Sits between board buttons and the
//   display/control logic; all outputs are registered in the clk domain.
// PARAMETERS
//   NUM_KEYS      4          number of independent key channels (>=1)
//   DEBOUNCE_CYC  1_000_000  consecutive stable cycles needed to accept a change (>=2)
//   MODE_NUM      2          states per mode counter (>=2); MODE_W = $clog2(MODE_NUM)
//   LONG_CYC      50_000_000 held cycles for a long press (> DEBOUNCE_CYC; used only with KEY_LONG_PRESS_EN)
// PORTS
//   clk         in   1                 system clock, 50 MHz
//   rstn        in   1                 asynchronous active-low reset
//   key_in      in   NUM_KEYS          raw keys, asynchronous, active-low (0 = pressed)
//   key_state   out  NUM_KEYS          debounced level, active-high (1 = pressed)
//   press_pulse out  NUM_KEYS          1-cycle pulse on accepted press
//   rel_pulse   out  NUM_KEYS          1-cycle pulse on accepted release
//   long_pulse  out  NUM_KEYS          1-cycle pulse at long-press threshold (0 if feature off)
//   mode_chg    out  NUM_KEYS          1-cycle pulse whenever that key's mode changes
//   mode        out  NUM_KEYS*MODE_W   key k mode at [k*MODE_W +: MODE_W]
// BEHAVIOUR
//   Reset: sync FFs = 1, stable = 1 (released), all counters 0, every output 0.
//   Sync: key_in -> s1 -> s2 every edge. Channels are fully independent.
//   Debounce (per key, cnt width $clog2(DEBOUNCE_CYC)):
//     s2 == stable -> cnt <= 0.  s2 != stable and cnt == DEBOUNCE_CYC-1 ->
//     stable <= s2, cnt <= 0.  otherwise cnt <= cnt+1.
//     Any bounce back to stable restarts the count; glitches < DEBOUNCE_CYC cycles ignored.
//   key_state = ~stable (registered). stable_d = stable delayed 1 cycle.
//   press_pulse = stable_d & ~stable, rel_pulse = ~stable_d & stable, both registered.
//   Latency: raw edge sampled at edge E -> key_state changes after edge E+DEBOUNCE_CYC+1,
//     press/rel_pulse high for the cycle after edge E+DEBOUNCE_CYC+2.
//   Mode counter: advance = mode==MODE_NUM-1 ? 0 : mode+1 (wrap, never exceeds MODE_NUM-1).
//     mode_chg asserted in the same cycle the new mode value first appears.
//   Simultaneous presses on several keys: each updates its own mode in the same cycle.
//   Reset asserted mid-press or mid-debounce: everything returns to reset values at once;
//     a key still held at reset release is re-debounced and yields a fresh press_pulse.
// CONFIGURATION
//   KEY_LONG_PRESS_EN defined:
//     hold counter (width $clog2(LONG_CYC+1)) counts while stable==0, cleared on release,
//     saturates at LONG_CYC; long_pulse fires once when it reaches LONG_CYC.
//     States per key: IDLE -> (press) HELD -> (hold==LONG_CYC) LONG -> (release) IDLE.
//     HELD -> (release) IDLE: mode advances, on the cycle of rel_pulse (short press).
//     Entering LONG: mode <= 0 on the long_pulse cycle (mode_chg only if mode was != 0);
//     the following release does not advance mode.
//   KEY_LONG_PRESS_EN undefined:
//     no hold counter; long_pulse tied 0; mode advances on the press_pulse cycle.
// TESTING (bench uses DEBOUNCE_CYC=4, MODE_NUM=3, LONG_CYC=20)
//   Reset then idle 10 cycles -> key_state=0, mode=0, all pulses 0.
//   key_in[0] low for 3 cycles then high -> no press_pulse, mode[0] stays 0.
//   key_in[0] low at edge E, held 10 cycles -> press_pulse[0] in cycle after E+6;
//     feature off: mode 0->1 with mode_chg[0]; three presses total -> mode 0 (wrap).
//   Feature on: hold key 1 for 30 cycles -> long_pulse[1] once, mode[1] forced 0, release no change;
//     hold 8 cycles -> mode[1] +1 on rel_pulse[1].
//   Keys 0 and 3 pressed same edge -> both press_pulse and mode_chg in same cycle.
//   Drop rstn during debounce of a held key -> all outputs 0; release rstn, still held
//     -> press_pulse 6 cycles later, mode restarts from 0.

Source files
------------

// File: rtl/key_mode_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_mode_multi
// Brief    : Multi-key push-button front end: synchroniser, debounce,
//            press/release pulses and a wrap-around mode counter per key.
//            Define KEY_LONG_PRESS_EN to add long-press detection.
// Revision : 1.0 - initial release
// ============================================================================
module key_mode_multi #(
    parameter int unsigned  NUM_KEYS     = 4,
    parameter int unsigned  DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned  MODE_NUM     = 2,
    parameter int unsigned  LONG_CYC     = 50_000_000,
    localparam int unsigned MODE_W       = $clog2(MODE_NUM)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_KEYS-1:0]        key_in,
    output logic [NUM_KEYS-1:0]        key_state,
    output logic [NUM_KEYS-1:0]        press_pulse,
    output logic [NUM_KEYS-1:0]        rel_pulse,
    output logic [NUM_KEYS-1:0]        long_pulse,
    output logic [NUM_KEYS-1:0]        mode_chg,
    output logic [NUM_KEYS*MODE_W-1:0] mode
);

    localparam int unsigned       CNT_W       = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [MODE_W-1:0] c_mode_last = MODE_W'(MODE_NUM - 1);

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       HOLD_W      = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_fsm_e;
`endif

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic              sync1_q;
        logic              sync2_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              stable_q;
        logic              stable_d;
        logic              stable_dly_q;
        logic              key_state_q;
        logic              press_q;
        logic              press_d;
        logic              rel_q;
        logic              rel_d;
        logic              long_q;
        logic              long_d;
        logic              chg_q;
        logic              chg_d;
        logic [MODE_W-1:0] mode_q;
        logic [MODE_W-1:0] mode_d;
        logic [MODE_W-1:0] mode_adv;

        // Any sample agreeing with the accepted level restarts the count.
        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_cnt_last) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        assign press_d  = stable_dly_q & ~stable_q;
        assign rel_d    = ~stable_dly_q & stable_q;
        assign mode_adv = (mode_q == c_mode_last) ? '0 : mode_q + MODE_W'(1);

`ifdef KEY_LONG_PRESS_EN
        key_fsm_e          state_q;
        key_fsm_e          state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;

        // Short press advances the mode on release; a long press forces mode 0.
        always_comb begin
            state_d = state_q;
            mode_d  = mode_q;
            chg_d   = 1'b0;
            long_d  = 1'b0;
            if (stable_q) begin
                hold_d = '0;
            end else if (hold_q == c_hold_max) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (press_d) begin
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (rel_d) begin
                        state_d = ST_IDLE;
                        mode_d  = mode_adv;
                        chg_d   = 1'b1;
                    end else if (!stable_q && (hold_q == c_hold_last)) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        mode_d  = '0;
                        chg_d   = (mode_q != '0);
                    end
                end
                ST_LONG: begin
                    if (rel_d) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end
`else
        always_comb begin
            mode_d = press_d ? mode_adv : mode_q;
            chg_d  = press_d;
            long_d = 1'b0;
        end
`endif

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync1_q      <= 1'b1;
                sync2_q      <= 1'b1;
                cnt_q        <= '0;
                stable_q     <= 1'b1;
                stable_dly_q <= 1'b1;
                key_state_q  <= 1'b0;
                press_q      <= 1'b0;
                rel_q        <= 1'b0;
                long_q       <= 1'b0;
                chg_q        <= 1'b0;
                mode_q       <= '0;
            end else begin
                sync1_q      <= key_in[k];
                sync2_q      <= sync1_q;
                cnt_q        <= cnt_d;
                stable_q     <= stable_d;
                stable_dly_q <= stable_q;
                key_state_q  <= ~stable_d;
                press_q      <= press_d;
                rel_q        <= rel_d;
                long_q       <= long_d;
                chg_q        <= chg_d;
                mode_q       <= mode_d;
            end
        end

        assign key_state[k]                 = key_state_q;
        assign press_pulse[k]               = press_q;
        assign rel_pulse[k]                 = rel_q;
        assign long_pulse[k]                = long_q;
        assign mode_chg[k]                  = chg_q;
        assign mode[k*MODE_W +: MODE_W]     = mode_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_mode_multi.sv
`default_nettype none
// Bench for key_mode_multi: behavioural per-key model checked every cycle,
// directed scenarios with literal expectations, then randomized key activity.
`timescale 1ns/1ps
module tb_key_mode_multi;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int MN = 3;
    localparam int LC = 20;
    localparam int MW = $clog2(MN);

    logic              clk  = 1'b0;
    logic              rstn = 1'b1;
    logic [NK-1:0]     key_in = '1;
    logic [NK-1:0]     key_state, press_pulse, rel_pulse, long_pulse, mode_chg;
    logic [NK*MW-1:0]  mode;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_mode_multi #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CYC (DB),
        .MODE_NUM     (MN),
        .LONG_CYC     (LC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_in      (key_in),
        .key_state   (key_state),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .long_pulse  (long_pulse),
        .mode_chg    (mode_chg),
        .mode        (mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dmode(input int k);
        return int'(mode[k*MW +: MW]);
    endfunction

    // ---------------- behavioural model ----------------
    // samp[k][i] holds the raw key level sampled i edges ago (index 0 = this edge).
    logic samp [NK][8];
    logic m_stab [NK];
    logic m_stab_old [NK];
    int   m_hold [NK];
    bit   m_long [NK];
    int   m_mode [NK];
    logic [NK-1:0] p_ks, p_press, p_rel, p_long, p_chg;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NK; k++) begin
                for (int i = 0; i < 8; i++) samp[k][i] = 1'b1;
                m_stab[k] = 1'b1; m_stab_old[k] = 1'b1;
                m_hold[k] = 0; m_long[k] = 1'b0; m_mode[k] = 0;
            end
            p_ks = '0; p_press = '0; p_rel = '0; p_long = '0; p_chg = '0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                bit pr, rl, flip;
                for (int i = 7; i > 0; i--) samp[k][i] = samp[k][i-1];
                samp[k][0] = key_in[k];
                pr = m_stab_old[k] & ~m_stab[k];
                rl = ~m_stab_old[k] & m_stab[k];
                p_press[k] = pr; p_rel[k] = rl; p_chg[k] = 1'b0; p_long[k] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
                if (m_stab[k] == 1'b0) begin
                    if (m_hold[k] < LC) begin
                        m_hold[k]++;
                        if (m_hold[k] == LC) begin
                            p_long[k] = 1'b1;
                            p_chg[k]  = (m_mode[k] != 0);
                            m_mode[k] = 0;
                            m_long[k] = 1'b1;
                        end
                    end
                end else begin
                    m_hold[k] = 0;
                end
                if (rl) begin
                    if (!m_long[k]) begin
                        m_mode[k] = (m_mode[k] + 1) % MN;
                        p_chg[k]  = 1'b1;
                    end
                    m_long[k] = 1'b0;
                end
`else
                if (pr) begin
                    m_mode[k] = (m_mode[k] + 1) % MN;
                    p_chg[k]  = 1'b1;
                end
`endif
                // Accept a new level once the synchronised input (2 edges late)
                // has disagreed with the current level for DB consecutive edges.
                flip = 1'b1;
                for (int i = 2; i < 2 + DB; i++) if (samp[k][i] == m_stab[k]) flip = 1'b0;
                m_stab_old[k] = m_stab[k];
                if (flip) m_stab[k] = ~m_stab[k];
                p_ks[k] = ~m_stab[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            check($sformatf("key_state[%0d]", k), 32'(key_state[k]), 32'(p_ks[k]));
            check($sformatf("press_pulse[%0d]", k), 32'(press_pulse[k]), 32'(p_press[k]));
            check($sformatf("rel_pulse[%0d]", k), 32'(rel_pulse[k]), 32'(p_rel[k]));
            check($sformatf("long_pulse[%0d]", k), 32'(long_pulse[k]), 32'(p_long[k]));
            check($sformatf("mode_chg[%0d]", k), 32'(mode_chg[k]), 32'(p_chg[k]));
            check($sformatf("mode[%0d]", k), 32'(dmode(k)), 32'(m_mode[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_evt(input int k, input bit rel, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((rel ? rel_pulse[k] : press_pulse[k]) == 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_evt key %0d rel=%0d: no pulse within 40 cycles, one required", k, rel);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lcnt;
        int run [NK];

        #1 rstn = 1'b0;
        step(3);
        rstn = 1'b1;
        step(10);
        @(negedge clk);
        check("idle key_state", 32'(key_state), 32'(0));
        check("idle mode", 32'(mode), 32'(0));
        check("idle pulses", 32'(press_pulse | rel_pulse | long_pulse | mode_chg), 32'(0));

        // 3-cycle glitch must be ignored
        step(1);
        key_in[0] = 1'b0;
        step(3);
        key_in[0] = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (press_pulse[0]) n = 1;
        end
        check("glitch press seen", 32'(n), 32'(0));
        check("glitch mode0", 32'(dmode(0)), 32'(0));

        // first accepted press: drive at P+2, sampled at E=P+10, pulse after E+6
        step(1);
        key_in[0] = 1'b0;
        wait_evt(0, 1'b0, n);
        check("press latency", 32'(n), 32'(8));
`ifdef KEY_LONG_PRESS_EN
        check("press mode0", 32'(dmode(0)), 32'(0));
        check("press chg0", 32'(mode_chg[0]), 32'(0));
`else
        check("press mode0", 32'(dmode(0)), 32'(1));
        check("press chg0", 32'(mode_chg[0]), 32'(1));
`endif
        step(9);
        key_in[0] = 1'b1;
        step(12);
        @(negedge clk);
        check("after 1 press mode0", 32'(dmode(0)), 32'(1));
        repeat (2) begin
            step(1);
            key_in[0] = 1'b0;
            step(10);
            key_in[0] = 1'b1;
            step(12);
        end
        @(negedge clk);
        check("wrap mode0", 32'(dmode(0)), 32'(0));

        // key 1: short press, long hold, short press
        step(1);
        key_in[1] = 1'b0;
        step(8);
        key_in[1] = 1'b1;
        step(12);
        @(negedge clk);
        check("short mode1", 32'(dmode(1)), 32'(1));
        step(1);
        key_in[1] = 1'b0;
        lcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lcnt += int'(long_pulse[1]);
        end
        step(1);
        key_in[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            lcnt += int'(long_pulse[1]);
        end
`ifdef KEY_LONG_PRESS_EN
        check("long pulse count", 32'(lcnt), 32'(1));
        check("long mode1", 32'(dmode(1)), 32'(0));
`else
        check("long pulse count", 32'(lcnt), 32'(0));
        check("long mode1", 32'(dmode(1)), 32'(2));
`endif
        step(1);
        key_in[1] = 1'b0;
        step(8);
        key_in[1] = 1'b1;
        step(12);
        @(negedge clk);
`ifdef KEY_LONG_PRESS_EN
        check("short2 mode1", 32'(dmode(1)), 32'(1));
`else
        check("short2 mode1", 32'(dmode(1)), 32'(0));
`endif

        // keys 0 and 3 on the same edge
        step(1);
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        wait_evt(0, 1'b0, n);
        check("simul press3", 32'(press_pulse[3]), 32'(1));
`ifndef KEY_LONG_PRESS_EN
        check("simul chg", 32'({mode_chg[3], mode_chg[0]}), 32'(3));
`endif
        step(5);
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        wait_evt(0, 1'b1, n);
        check("simul rel3", 32'(rel_pulse[3]), 32'(1));
`ifdef KEY_LONG_PRESS_EN
        check("simul chg", 32'({mode_chg[3], mode_chg[0]}), 32'(3));
`endif
        step(12);

        // reset in the middle of debouncing a held key
        key_in[2] = 1'b0;
        step(3);
        rstn = 1'b0;
        @(negedge clk);
        check("rst key_state", 32'(key_state), 32'(0));
        check("rst pulses", 32'(press_pulse | rel_pulse | long_pulse | mode_chg), 32'(0));
        check("rst mode", 32'(mode), 32'(0));
        step(2);
        rstn = 1'b1;
        wait_evt(2, 1'b0, n);
        check("re-press latency", 32'(n), 32'(8));
`ifdef KEY_LONG_PRESS_EN
        check("re-press mode2", 32'(dmode(2)), 32'(0));
`else
        check("re-press mode2", 32'(dmode(2)), 32'(1));
`endif
        check("re-press mode0", 32'(dmode(0)), 32'(0));
        step(1);
        key_in[2] = 1'b1;
        step(12);

        // randomized activity: short glitches, normal presses, long holds, rare resets
        for (int k = 0; k < NK; k++) run[k] = $urandom_range(1, 10);
        for (int c = 0; c < 4000; c++) begin
            step(1);
            for (int k = 0; k < NK; k++) begin
                run[k]--;
                if (run[k] <= 0) begin
                    key_in[k] = ~key_in[k];
                    run[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40)
                                                         : $urandom_range(1, 10);
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                step(2);
                rstn = 1'b1;
            end
        end
        key_in = '1;
        step(20);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
